// File: rtl/mastermind_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_round_engine
//  Description : Code-breaker round controller. Collects a guess digit by
//                digit, scores exact and colour-only matches (repeated
//                colours counted correctly), tracks lives and keeps
//                saturating scores for players A and B.
//  Revision    : 1.0  initial release
// ============================================================================
module mastermind_round_engine #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 3,
    parameter int LIVES   = 3,
    parameter int PTS_W   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           breaker_sel,
    input  logic [DIGITS*DIGIT_W-1:0]      secret,
    input  logic [DIGIT_W-1:0]             sw,
    input  logic                           enter_a,
    input  logic                           enter_b,
    input  logic                           load_pts,
    input  logic [PTS_W-1:0]               init_pt_a,
    input  logic [PTS_W-1:0]               init_pt_b,
    output logic [DIGITS*DIGIT_W-1:0]      guess,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt,
    output logic [$clog2(DIGITS+1)-1:0]    exact,
    output logic [$clog2(DIGITS+1)-1:0]    partial,
    output logic                           result_valid,
    output logic [$clog2(LIVES+1)-1:0]     lives_left,
    output logic [PTS_W-1:0]               points_a,
    output logic [PTS_W-1:0]               points_b,
    output logic                           busy,
    output logic                           round_over,
    output logic                           breaker_won
);

    localparam int c_CNT_W  = $clog2(DIGITS+1);
    localparam int c_LIFE_W = $clog2(LIVES+1);
    localparam int c_CODE_W = DIGITS*DIGIT_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_EXACT  = 3'd2,
        S_COLOR  = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_CODE_W-1:0]    r_secret;
    logic                   r_breaker;
    logic [c_CODE_W-1:0]    r_guess;
    logic [c_CNT_W-1:0]     r_digit_cnt;
    logic [c_CNT_W-1:0]     r_exact;
    logic [c_CNT_W-1:0]     r_partial;
    logic [c_CNT_W-1:0]     r_total;
    logic [DIGIT_W-1:0]     r_color;
    logic [c_LIFE_W-1:0]    r_lives;
    logic [PTS_W-1:0]       r_pts_a;
    logic [PTS_W-1:0]       r_pts_b;
    logic                   r_result_valid;
    logic                   r_busy;
    logic                   r_round_over;
    logic                   r_breaker_won;

    logic                   w_strobe;
    logic                   w_last_digit;
    logic                   w_last_color;
    logic                   w_won;
    logic                   w_last_life;
    logic                   w_idle_like;
    logic [c_CNT_W-1:0]     w_exact_cnt;
    logic [c_CNT_W-1:0]     w_sec_cnt;
    logic [c_CNT_W-1:0]     w_gue_cnt;
    logic [c_CNT_W-1:0]     w_min_cnt;
    logic [c_CNT_W-1:0]     w_total_next;

    // Only the latched breaker's strobe counts, and only while entering.
    assign w_strobe     = (r_state == S_ENTRY) && (r_breaker ? enter_b : enter_a);
    assign w_last_digit = w_strobe && (r_digit_cnt == c_CNT_W'(DIGITS-1));
    assign w_last_color = (r_color == {DIGIT_W{1'b1}});
    assign w_won        = (r_exact == c_CNT_W'(DIGITS));
    assign w_last_life  = (r_lives == c_LIFE_W'(1));
    assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE);

    // Per-position exact count and per-colour occurrence counts for the
    // colour currently being swept.
    always_comb begin
        w_exact_cnt = '0;
        w_sec_cnt   = '0;
        w_gue_cnt   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_guess[i*DIGIT_W +: DIGIT_W] == r_secret[i*DIGIT_W +: DIGIT_W])
                w_exact_cnt = w_exact_cnt + c_CNT_W'(1);
            if (r_secret[i*DIGIT_W +: DIGIT_W] == r_color)
                w_sec_cnt = w_sec_cnt + c_CNT_W'(1);
            if (r_guess[i*DIGIT_W +: DIGIT_W] == r_color)
                w_gue_cnt = w_gue_cnt + c_CNT_W'(1);
        end
        w_min_cnt    = (w_sec_cnt < w_gue_cnt) ? w_sec_cnt : w_gue_cnt;
        w_total_next = r_total + w_min_cnt;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start)
                    w_state_next = S_ENTRY;
            end
            S_ENTRY: begin
                if (w_last_digit)
                    w_state_next = S_EXACT;
            end
            S_EXACT: begin
                w_state_next = S_COLOR;
            end
            S_COLOR: begin
                if (w_last_color)
                    w_state_next = S_REPORT;
            end
            S_REPORT: begin
                if (w_won || w_last_life)
                    w_state_next = S_DONE;
                else
                    w_state_next = S_ENTRY;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Guess entry, scoring datapath, lives and scores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_secret      <= '0;
            r_breaker     <= 1'b0;
            r_guess       <= '0;
            r_digit_cnt   <= '0;
            r_exact       <= '0;
            r_partial     <= '0;
            r_total       <= '0;
            r_color       <= '0;
            r_lives       <= '0;
            r_pts_a       <= '0;
            r_pts_b       <= '0;
            r_breaker_won <= 1'b0;
        end else begin
            // Score preload and round start may coincide; both apply.
            if (w_idle_like && load_pts) begin
                r_pts_a <= init_pt_a;
                r_pts_b <= init_pt_b;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_secret      <= secret;
                        r_breaker     <= breaker_sel;
                        r_lives       <= c_LIFE_W'(LIVES);
                        r_guess       <= '0;
                        r_digit_cnt   <= '0;
                        r_breaker_won <= 1'b0;
                    end
                end
                S_ENTRY: begin
                    if (w_strobe) begin
                        r_guess     <= {r_guess[c_CODE_W-DIGIT_W-1:0], sw};
                        r_digit_cnt <= r_digit_cnt + c_CNT_W'(1);
                    end
                end
                S_EXACT: begin
                    r_exact <= w_exact_cnt;
                    r_total <= '0;
                    r_color <= '0;
                end
                S_COLOR: begin
                    r_total <= w_total_next;
                    r_color <= r_color + DIGIT_W'(1);
                    // Total common colours always covers the exact hits.
                    if (w_last_color)
                        r_partial <= w_total_next - r_exact;
                end
                S_REPORT: begin
                    if (w_won) begin
                        r_breaker_won <= 1'b1;
                        if (!r_breaker) begin
                            if (r_pts_a != {PTS_W{1'b1}})
                                r_pts_a <= r_pts_a + PTS_W'(1);
                        end else begin
                            if (r_pts_b != {PTS_W{1'b1}})
                                r_pts_b <= r_pts_b + PTS_W'(1);
                        end
                    end else begin
                        r_lives <= r_lives - c_LIFE_W'(1);
                        if (w_last_life) begin
                            r_breaker_won <= 1'b0;
                            // Codemaker is the player who is not breaking.
                            if (r_breaker) begin
                                if (r_pts_a != {PTS_W{1'b1}})
                                    r_pts_a <= r_pts_a + PTS_W'(1);
                            end else begin
                                if (r_pts_b != {PTS_W{1'b1}})
                                    r_pts_b <= r_pts_b + PTS_W'(1);
                            end
                        end else begin
                            r_guess     <= '0;
                            r_digit_cnt <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_round_over   <= 1'b0;
        end else begin
            r_result_valid <= (w_state_next == S_REPORT);
            r_busy         <= (w_state_next == S_ENTRY) || (w_state_next == S_EXACT) ||
                              (w_state_next == S_COLOR) || (w_state_next == S_REPORT);
            r_round_over   <= (w_state_next == S_DONE);
        end
    end

    assign guess        = r_guess;
    assign digit_cnt    = r_digit_cnt;
    assign exact        = r_exact;
    assign partial      = r_partial;
    assign result_valid = r_result_valid;
    assign lives_left   = r_lives;
    assign points_a     = r_pts_a;
    assign points_b     = r_pts_b;
    assign busy         = r_busy;
    assign round_over   = r_round_over;
    assign breaker_won  = r_breaker_won;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_round_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mastermind_round_engine
//  Description : Directed self-checking bench for mastermind_round_engine
//                with hand-computed expected scores, lives and points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mastermind_round_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic        breaker_sel;
    logic [11:0] secret;
    logic [2:0]  sw;
    logic        enter_a;
    logic        enter_b;
    logic        load_pts;
    logic [1:0]  init_pt_a;
    logic [1:0]  init_pt_b;
    logic [11:0] guess;
    logic [2:0]  digit_cnt;
    logic [2:0]  exact;
    logic [2:0]  partial;
    logic        result_valid;
    logic [1:0]  lives_left;
    logic [1:0]  points_a;
    logic [1:0]  points_b;
    logic        busy;
    logic        round_over;
    logic        breaker_won;

    int checks = 0;
    int errors = 0;

    mastermind_round_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .breaker_sel  (breaker_sel),
        .secret       (secret),
        .sw           (sw),
        .enter_a      (enter_a),
        .enter_b      (enter_b),
        .load_pts     (load_pts),
        .init_pt_a    (init_pt_a),
        .init_pt_b    (init_pt_b),
        .guess        (guess),
        .digit_cnt    (digit_cnt),
        .exact        (exact),
        .partial      (partial),
        .result_valid (result_valid),
        .lives_left   (lives_left),
        .points_a     (points_a),
        .points_b     (points_b),
        .busy         (busy),
        .round_over   (round_over),
        .breaker_won  (breaker_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Pack four digits given in entry order (first entered is the top digit).
    function automatic logic [11:0] p4(input int a, input int b, input int c, input int d);
        logic [11:0] r;
        r = {a[2:0], b[2:0], c[2:0], d[2:0]};
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [11:0] sec, input logic br);
        secret      = sec;
        breaker_sel = br;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic key(input int d, input logic br);
        sw = d[2:0];
        if (br) enter_b = 1'b1;
        else    enter_a = 1'b1;
        tick();
        enter_a = 1'b0;
        enter_b = 1'b0;
    endtask

    task automatic guess4(input int a, input int b, input int c, input int d, input logic br);
        key(a, br);
        key(b, br);
        key(c, br);
        key(d, br);
    endtask

    // Wait (bounded) for the result pulse, check latency and score, then
    // step past the REPORT edge and confirm the pulse lasted one cycle.
    task automatic score(input string tag, input int ex, input int pa);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_exact"}, exact, ex);
        chk({tag, "_partial"}, partial, pa);
        tick();
        chk({tag, "_rv_low"}, result_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; breaker_sel = 1'b0; secret = '0; sw = '0;
        enter_a = 1'b0; enter_b = 1'b0; load_pts = 1'b0; init_pt_a = '0; init_pt_b = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_guess", guess, 0);
        chk("rst_digit_cnt", digit_cnt, 0);
        chk("rst_lives", lives_left, 0);
        chk("rst_points", {points_a, points_b}, 0);
        chk("rst_flags", {result_valid, busy, round_over, breaker_won}, 0);

        // Round 1: A breaks 1,2,3,4 first time; stray enter_b ignored.
        start_round(p4(1, 2, 3, 4), 1'b0);
        chk("r1_busy", busy, 1);
        chk("r1_lives", lives_left, 3);
        key(1, 1'b0);
        key(2, 1'b0);
        chk("r1_cnt2", digit_cnt, 2);
        chk("r1_guess2", guess, p4(0, 0, 1, 2));
        sw = 3'd5; enter_b = 1'b1; tick(); enter_b = 1'b0;
        chk("r1_b_ign_cnt", digit_cnt, 2);
        chk("r1_b_ign_guess", guess, p4(0, 0, 1, 2));
        sw = 3'd3; enter_a = 1'b1; enter_b = 1'b1; tick(); enter_a = 1'b0; enter_b = 1'b0;
        chk("r1_both_cnt", digit_cnt, 3);
        key(4, 1'b0);
        score("r1", 4, 0);
        chk("r1_pts_a", points_a, 1);
        chk("r1_won", breaker_won, 1);
        chk("r1_over", round_over, 1);
        chk("r1_lives_end", lives_left, 3);
        chk("r1_busy_end", busy, 0);
        key(6, 1'b0);
        chk("r1_done_strobe", guess, p4(1, 2, 3, 4));

        // Round 2: all-partial guess, then ignored restart, then win.
        start_round(p4(1, 2, 3, 4), 1'b0);
        chk("r2_over_clr", {round_over, breaker_won}, 0);
        guess4(4, 3, 2, 1, 1'b0);
        score("r2a", 0, 4);
        chk("r2a_lives", lives_left, 2);
        chk("r2a_cnt", digit_cnt, 0);
        chk("r2a_guess", guess, 0);
        chk("r2a_busy", busy, 1);
        start_round(p4(7, 7, 7, 7), 1'b1);
        chk("r2_start_ign", lives_left, 2);
        guess4(1, 2, 3, 4, 1'b0);
        score("r2b", 4, 0);
        chk("r2b_pts_a", points_a, 2);
        chk("r2b_lives", lives_left, 2);

        // Round 3: repeated colours; A runs out of lives, B scores.
        start_round(p4(1, 2, 1, 3), 1'b0);
        guess4(1, 1, 5, 5, 1'b0);
        score("r3a", 1, 1);
        guess4(1, 1, 1, 1, 1'b0);
        score("r3b", 2, 0);
        chk("r3b_lives", lives_left, 1);
        guess4(7, 7, 7, 7, 1'b0);
        score("r3c", 0, 0);
        chk("r3_lives", lives_left, 0);
        chk("r3_pts", {points_a, points_b}, {2'd2, 2'd1});
        chk("r3_flags", {round_over, breaker_won}, 2'b10);

        // Round 4: repeated colours, then reset mid-COLOR.
        start_round(p4(1, 1, 2, 3), 1'b0);
        guess4(1, 1, 1, 1, 1'b0);
        score("r4a", 2, 0);
        chk("r4a_lives", lives_left, 2);
        guess4(0, 0, 0, 0, 1'b0);
        repeat (4) tick();
        chk("r4_in_color", {busy, result_valid}, 2'b10);
        reset = 1'b1;
        #1;
        chk("r4_rst_guess", guess, 0);
        chk("r4_rst_cnts", {digit_cnt, exact, partial}, 0);
        chk("r4_rst_lives", lives_left, 0);
        chk("r4_rst_points", {points_a, points_b}, 0);
        chk("r4_rst_flags", {result_valid, busy, round_over, breaker_won}, 0);
        tick();
        reset = 1'b0;

        // Round 5: B breaks and loses three times; A (codemaker) scores.
        start_round(p4(0, 1, 2, 3), 1'b1);
        chk("r5_lives", lives_left, 3);
        chk("r5_busy", busy, 1);
        key(7, 1'b0);
        chk("r5_a_ign", digit_cnt, 0);
        for (int g = 0; g < 3; g++) begin
            guess4(7, 7, 7, 7, 1'b1);
            score("r5", 0, 0);
            chk("r5_lives_dec", lives_left, 2 - g);
        end
        chk("r5_pts", {points_a, points_b}, {2'd1, 2'd0});
        chk("r5_flags", {round_over, breaker_won}, 2'b10);

        // Round 6: preload with start, ignored mid-round load, saturation.
        init_pt_a = 2'd3; init_pt_b = 2'd2; load_pts = 1'b1;
        start_round(p4(1, 2, 3, 4), 1'b0);
        load_pts = 1'b0;
        chk("r6_load", {points_a, points_b}, {2'd3, 2'd2});
        chk("r6_lives", lives_left, 3);
        init_pt_a = 2'd0; init_pt_b = 2'd0; load_pts = 1'b1;
        tick();
        load_pts = 1'b0;
        chk("r6_load_ign", {points_a, points_b}, {2'd3, 2'd2});
        guess4(1, 2, 3, 4, 1'b0);
        score("r6", 4, 0);
        chk("r6_sat", {points_a, points_b}, {2'd3, 2'd2});
        chk("r6_won", breaker_won, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
